// File: rtl/anc_pkg.sv
// Shared constants for the ANC per-sample frame sequencer.
package anc_pkg;

    localparam int ANC_SAMPLE_W = 11;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CAPTURE    = 3'd1;
    localparam logic [2:0] FILT_WAIT  = 3'd2;
    localparam logic [2:0] SAT        = 3'd3;
    localparam logic [2:0] ERR        = 3'd4;
    localparam logic [2:0] WUPD_ISSUE = 3'd5;
    localparam logic [2:0] WUPD_WAIT  = 3'd6;

endpackage

// File: rtl/anc_seq_if.sv
// Control/status bundle between the ANC datapath and its per-sample sequencer.
interface anc_seq_if
    import anc_pkg::*;
#(
    parameter int FRAME_W = 16
) ();

    logic                    Enable;
    logic                    SampleStrobe;
    logic [ANC_SAMPLE_W-1:0] MicIn;
    logic                    FiltDone;
    logic                    WUpdDone;
    logic                    ClrStatus;
    logic [ANC_SAMPLE_W-1:0] MicSample;
    logic                    FiltStart;
    logic                    SatLatch;
    logic                    ErrLatch;
    logic                    WUpdStart;
    logic                    Busy;
    logic                    Overrun;
    logic                    Timeout;
    logic [FRAME_W-1:0]      FrameCount;
    logic [2:0]              State;

    modport slave (
        input  Enable, SampleStrobe, MicIn, FiltDone, WUpdDone, ClrStatus,
        output MicSample, FiltStart, SatLatch, ErrLatch, WUpdStart,
               Busy, Overrun, Timeout, FrameCount, State
    );

    modport master (
        output Enable, SampleStrobe, MicIn, FiltDone, WUpdDone, ClrStatus,
        input  MicSample, FiltStart, SatLatch, ErrLatch, WUpdStart,
               Busy, Overrun, Timeout, FrameCount, State
    );

endinterface

// File: rtl/anc_edge_detect.sv
// Delay flop and rising-edge pulse for the filter-complete level.
module anc_edge_detect (
    input  logic Clk_100M,
    input  logic Reset,
    input  logic din,
    output logic rise
);

    logic dly;

    always_ff @(posedge Clk_100M) begin
        if (!Reset) dly <= 1'b0;
        else        dly <= din;
    end

    assign rise = din & ~dly;

endmodule

// File: rtl/anc_sample_sequencer.sv
// Per-sample ANC frame sequencer: capture, filter, saturate, error, weight update.
// Optional wait-state abort timers are built when ANC_SEQ_TIMEOUT_EN is defined.
//
//  state      | meaning
//  IDLE       | waiting for an enabled sample strobe
//  CAPTURE    | sample captured, FiltStart pulsed
//  FILT_WAIT  | waiting for FiltDone rising edge
//  SAT        | SatLatch pulsed
//  ERR        | ErrLatch pulsed (after SAT: error stage reads the saturated value)
//  WUPD_ISSUE | WUpdStart pulsed
//  WUPD_WAIT  | waiting for WUpdDone, then frame counted
module anc_sample_sequencer
    import anc_pkg::*;
#(
    parameter int FILT_TIMEOUT = 2000,
    parameter int WUPD_TIMEOUT = 2000,
    parameter int TMO_W        = 12,
    parameter int FRAME_W      = 16
) (
    input  logic      Clk_100M,
    input  logic      Reset,
    anc_seq_if.slave  ifc
);

    if (FILT_TIMEOUT < 1 || FILT_TIMEOUT > (1 << TMO_W) ||
        WUPD_TIMEOUT < 1 || WUPD_TIMEOUT > (1 << TMO_W)) begin : gBadTimeout
        $error("anc_sample_sequencer: timeout limits do not fit TMO_W");
    end

    logic [2:0]              state;
    logic [ANC_SAMPLE_W-1:0] micSample;
    logic [FRAME_W-1:0]      frameCount;
    logic                    overrun;
    logic                    busy;
    logic                    filtRise;
    logic                    tmoHit;

    assign busy = (state != IDLE);

    anc_edge_detect uFiltEdge (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .din      (ifc.FiltDone),
        .rise     (filtRise)
    );

`ifdef ANC_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmoCnt;
    logic             inWait;
    logic             timeoutFlag;
    logic             timeoutSet;

    assign inWait = (state == FILT_WAIT) || (state == WUPD_WAIT);
    assign tmoHit = inWait && (tmoCnt == '0);
    // A done arriving on the limit cycle still completes the frame.
    assign timeoutSet = tmoHit && ((state == FILT_WAIT) ? !filtRise : !ifc.WUpdDone);

    always_ff @(posedge Clk_100M) begin
        if (!Reset)                         tmoCnt <= '0;
        else if (state == CAPTURE)          tmoCnt <= TMO_W'(FILT_TIMEOUT - 1);
        else if (state == WUPD_ISSUE)       tmoCnt <= TMO_W'(WUPD_TIMEOUT - 1);
        else if (inWait && tmoCnt != '0)    tmoCnt <= tmoCnt - 1'b1;
    end

    always_ff @(posedge Clk_100M) begin
        if (!Reset)             timeoutFlag <= 1'b0;
        else if (timeoutSet)    timeoutFlag <= 1'b1;
        else if (ifc.ClrStatus) timeoutFlag <= 1'b0;
    end

    assign ifc.Timeout = timeoutFlag;
`else
    assign tmoHit      = 1'b0;
    assign ifc.Timeout = 1'b0;
`endif

    always_ff @(posedge Clk_100M) begin
        if (!Reset) begin
            state      <= IDLE;
            micSample  <= '0;
            frameCount <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifc.SampleStrobe && ifc.Enable) begin
                        state     <= CAPTURE;
                        micSample <= ifc.MicIn;
                    end
                end
                CAPTURE:    state <= FILT_WAIT;
                FILT_WAIT: begin
                    if (filtRise)    state <= SAT;
                    else if (tmoHit) state <= IDLE;
                end
                SAT:        state <= ERR;
                ERR:        state <= WUPD_ISSUE;
                WUPD_ISSUE: state <= WUPD_WAIT;
                WUPD_WAIT: begin
                    if (ifc.WUpdDone) begin
                        state      <= IDLE;
                        frameCount <= frameCount + 1'b1;
                    end else if (tmoHit) begin
                        state <= IDLE;
                    end
                end
                default:    state <= IDLE;
            endcase

            // Busy includes the WUPD_WAIT exit cycle, so no back-to-back accept.
            if (ifc.SampleStrobe && busy) overrun <= 1'b1;
            else if (ifc.ClrStatus)       overrun <= 1'b0;
        end
    end

    assign ifc.MicSample  = micSample;
    assign ifc.FiltStart  = (state == CAPTURE);
    assign ifc.SatLatch   = (state == SAT);
    assign ifc.ErrLatch   = (state == ERR);
    assign ifc.WUpdStart  = (state == WUPD_ISSUE);
    assign ifc.Busy       = busy;
    assign ifc.Overrun    = overrun;
    assign ifc.FrameCount = frameCount;
    assign ifc.State      = state;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Directed + randomized bench for anc_sample_sequencer; expectations come from a frame timeline model.
module tb_anc_sample_sequencer;
    import anc_pkg::*;

    localparam int FRAME_W = 8;

    logic Clk_100M = 1'b0;
    logic Reset    = 1'b0;

    int nChecks = 0;
    int nPass   = 0;

    logic [FRAME_W-1:0] expFc  = '0;
    logic               expOv  = 1'b0;
    logic               expTmo = 1'b0;

    anc_seq_if #(.FRAME_W(FRAME_W)) ifc ();

    anc_sample_sequencer #(
        .FILT_TIMEOUT (8),
        .WUPD_TIMEOUT (16),
        .TMO_W        (12),
        .FRAME_W      (FRAME_W)
    ) dut (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .ifc      (ifc)
    );

    always #5 Clk_100M = ~Clk_100M;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk_100M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] ctlObs();
        return {ifc.FiltStart, ifc.SatLatch, ifc.ErrLatch, ifc.WUpdStart,
                ifc.Busy, ifc.Overrun, ifc.Timeout};
    endfunction

    function automatic logic [28:0] allObs();
        return {ifc.MicSample, ifc.FiltStart, ifc.SatLatch, ifc.ErrLatch, ifc.WUpdStart,
                ifc.Busy, ifc.Overrun, ifc.Timeout, ifc.FrameCount, ifc.State};
    endfunction

    // One frame on a timeline: strobe in cycle 0, FiltDone rises in cycle r, WUpdDone in cycle w.
    // Outputs in cycle c reflect inputs of cycle c-1.
    task automatic doFrame(input logic [10:0] mic, input int r, input int w, input bit startHigh,
                           input int strayAt, input int clrAt, input bit enDrop, input bit strayW);
        logic [6:0] expV;
        ifc.MicIn        = mic;
        ifc.SampleStrobe = 1'b1;
        ifc.Enable       = 1'b1;
        ifc.FiltDone     = startHigh;
        ifc.WUpdDone     = 1'b0;
        ifc.ClrStatus    = 1'b0;
        for (int c = 1; c <= w + 1; c++) begin
            step();
            if (c == w + 1) expFc++;
            expV = {c == 1, c == r + 1, c == r + 2, c == r + 3, c <= w, expOv, expTmo};
            chk("frame_ctl", ctlObs(), expV);
            if (c == 1 || c == w + 1) chk("mic_sample", ifc.MicSample, mic);
            if (c == w + 1) begin
                chk("frame_count", ifc.FrameCount, expFc);
                chk("frame_end_state", ifc.State, IDLE);
            end
            ifc.SampleStrobe = (c == strayAt);
            ifc.ClrStatus    = (c == clrAt);
            if (c == strayAt)     expOv = 1'b1;
            else if (c == clrAt)  expOv = 1'b0;
            if (c == clrAt)       expTmo = 1'b0;
            ifc.MicIn    = 11'($urandom);
            ifc.FiltDone = (c >= r) || (startHigh && c < r - 1);
            ifc.WUpdDone = (c == w) || (strayW && c == 2);
            ifc.Enable   = !enDrop;
        end
    endtask

    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.Enable       = 1'($urandom_range(1, 0));
            ifc.SampleStrobe = !ifc.Enable && 1'($urandom_range(1, 0));
            ifc.ClrStatus    = 1'b0;
            ifc.WUpdDone     = 1'($urandom_range(1, 0));
            ifc.FiltDone     = 1'($urandom_range(1, 0));
            step();
            chk("idle", {ifc.Busy, ifc.FiltStart, ifc.SatLatch, ifc.Overrun, ifc.Timeout},
                {3'b000, expOv, expTmo});
        end
    endtask

    task automatic clearStatus();
        ifc.SampleStrobe = 1'b0;
        ifc.ClrStatus    = 1'b1;
        step();
        ifc.ClrStatus = 1'b0;
        expOv  = 1'b0;
        expTmo = 1'b0;
        chk("status_clear", {ifc.Overrun, ifc.Timeout}, 2'b00);
    endtask

    initial begin
        int r, w, strayAt, clrAt;
        bit sh;

        ifc.Enable = 1'b0; ifc.SampleStrobe = 1'b0; ifc.MicIn = '0;
        ifc.FiltDone = 1'b0; ifc.WUpdDone = 1'b0; ifc.ClrStatus = 1'b0;

        // Reset state
        step(); step();
        chk("reset_outputs", allObs(), '0);
        Reset = 1'b1;

        // Nominal frame: strobe T0, FiltDone T10, WUpdDone T20
        doFrame(11'h155, 10, 20, 1'b0, -1, -1, 1'b0, 1'b0);
        chk("nominal_count", ifc.FrameCount, 1);
        idleGap(3);

        // Overrun in FILT_WAIT, then clear
        doFrame(11'h2AA, 6, 12, 1'b0, 4, -1, 1'b0, 1'b0);
        chk("overrun_set", ifc.Overrun, 1'b1);
        clearStatus();

        // Set and clear in the same cycle: set wins; stray WUpdDone in FILT_WAIT ignored
        doFrame(11'h4F1, 5, 11, 1'b0, 8, 8, 1'b0, 1'b1);
        // Strobe on the WUPD_WAIT exit cycle is an overrun; Enable dropped mid-frame
        doFrame(11'h0F0, 4, 10, 1'b0, 10, -1, 1'b1, 1'b0);
        idleGap(1);
        clearStatus();

        // Enable=0 strobe ignored
        ifc.Enable = 1'b0; ifc.SampleStrobe = 1'b1;
        step();
        ifc.SampleStrobe = 1'b0;
        chk("enable0_busy", {ifc.Busy, ifc.Overrun}, 2'b00);
        step();
        chk("enable0_nostart", {ifc.Busy, ifc.FiltStart}, 2'b00);
        ifc.Enable = 1'b1;

        // Filter wait without FiltDone
        ifc.MicIn = 11'h0A5; ifc.SampleStrobe = 1'b1; ifc.FiltDone = 1'b0;
        ifc.WUpdDone = 1'b0; ifc.ClrStatus = 1'b0;
        step();
        ifc.SampleStrobe = 1'b0;
        chk("tmo_filtstart", ifc.FiltStart, 1'b1);
`ifdef ANC_SEQ_TIMEOUT_EN
        for (int c = 2; c <= 10; c++) begin
            step();
            chk("tmo_wait", {ifc.Busy, ifc.SatLatch, ifc.Timeout}, {c <= 9, 1'b0, c == 10});
        end
        expTmo = 1'b1;
        chk("tmo_count_kept", ifc.FrameCount, expFc);
        chk("tmo_state", ifc.State, IDLE);
        clearStatus();
`else
        for (int c = 2; c <= 40; c++) begin
            step();
            chk("no_tmo_wait", {ifc.Busy, ifc.SatLatch, ifc.Timeout, ifc.State}, {3'b100, FILT_WAIT});
        end
        ifc.FiltDone = 1'b1;
        step();
        chk("no_tmo_sat", ifc.SatLatch, 1'b1);
        step(); step(); step();
        chk("no_tmo_wupd_wait", ifc.State, WUPD_WAIT);
        ifc.WUpdDone = 1'b1;
        step();
        ifc.WUpdDone = 1'b0; ifc.FiltDone = 1'b0;
        expFc++;
        chk("no_tmo_done", {ifc.Busy, ifc.FrameCount}, {1'b0, expFc});
`endif

        // Reset in ERR, with Overrun set and FrameCount nonzero
        ifc.MicIn = 11'h3C3; ifc.SampleStrobe = 1'b1; ifc.FiltDone = 1'b0;
        step();
        ifc.SampleStrobe = 1'b0;
        step();
        ifc.SampleStrobe = 1'b1;
        step();
        ifc.SampleStrobe = 1'b0; ifc.FiltDone = 1'b1;
        step(); step();
        chk("rst_in_err", {ifc.ErrLatch, ifc.Overrun}, 2'b11);
        Reset = 1'b0;
        step();
        chk("rst_midframe_outputs", allObs(), '0);
        Reset = 1'b1;
        expFc = '0; expOv = 1'b0; expTmo = 1'b0;
        step();
        chk("rst_release_idle", ifc.Busy, 1'b0);
        // FiltDone held high across reset and frame entry: only the later rise counts
        doFrame(11'h7FF, 6, 12, 1'b1, -1, -1, 1'b0, 1'b1);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(9, 2);
            w  = r + $urandom_range(10, 4);
            sh = (r >= 4) ? 1'($urandom_range(1, 0)) : 1'b0;
            strayAt = ($urandom_range(1, 0) != 0) ? int'($urandom_range(w, 1)) : -1;
            clrAt   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(w, 1)) : -1;
            doFrame(11'($urandom), r, w, sh, strayAt, clrAt,
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            idleGap($urandom_range(3, 1));
        end

        // Back-to-back short frames up to the counter wrap
        while (expFc != '1) doFrame(11'($urandom), 2, 6, 1'b0, -1, -1, 1'b0, 1'b0);
        chk("count_max", ifc.FrameCount, {FRAME_W{1'b1}});
        doFrame(11'h001, 2, 6, 1'b0, -1, -1, 1'b0, 1'b0);
        chk("count_wrap", ifc.FrameCount, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
